// File: rtl/trap_controller_pkg.sv
// Shared trap definitions: CSR addresses, cause codes, mstatus fields, FSM states.
package trap_controller_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [31:0] CAUSE_IRQ_EXT = 32'h8000_000B;
  localparam logic [31:0] CAUSE_IRQ_TMR = 32'h8000_0007;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_BREAK   = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_EPC,
    ST_WR_CAUSE,
    ST_WR_TVAL,
    ST_WR_STATUS,
    ST_REDIRECT,
    ST_MRET_STATUS
  } trap_state_t;

  // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode as previous.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE, MPP stays machine.
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/trap_cause_encoder.sv
// Combinational priority encoder: decoder flags + gated irqs -> trap cause/tval.
module trap_cause_encoder
  import trap_controller_pkg::*;
(
  input  logic        illegal_ins_in,
  input  logic        ecall_in,
  input  logic        ebreak_in,
  input  logic        mret_in,
  input  logic        irq_ext_in,
  input  logic        irq_tmr_in,
  input  logic        mie_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic        take_trap,
  output logic        is_mret,
  output logic        is_irq,
  output logic [31:0] cause,
  output logic [31:0] tval
);

  // Fixed priority: ext irq > timer irq > illegal > ebreak > ecall > mret.
  always_comb begin
    take_trap = 1'b1;
    is_mret   = 1'b0;
    is_irq    = 1'b0;
    cause     = 32'd0;
    tval      = 32'd0;
    if (irq_ext_in && mie_in) begin
      is_irq = 1'b1;
      cause  = CAUSE_IRQ_EXT;
    end else if (irq_tmr_in && mie_in) begin
      is_irq = 1'b1;
      cause  = CAUSE_IRQ_TMR;
    end else if (illegal_ins_in) begin
      cause = CAUSE_ILLEGAL;
      tval  = instr_in;
    end else if (ebreak_in) begin
      cause = CAUSE_BREAK;
      tval  = pc_in;
    end else if (ecall_in) begin
      cause = CAUSE_ECALL_M;
    end else begin
      take_trap = 1'b0;
      is_mret   = mret_in;
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: CSR write sequence, PC redirect and flush.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        illegal_ins_in,
  input  logic        ecall_in,
  input  logic        ebreak_in,
  input  logic        mret_in,
  input  logic        irq_ext_in,
  input  logic        irq_tmr_in,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        csr_wr_valid_out,
  output logic [11:0] csr_wr_addr_out,
  output logic [31:0] csr_wr_data_out,
  input  logic        csr_wr_ready_in,
  output logic        stall_out,
  output logic        flush_out,
  output logic        pc_redirect_valid_out,
  output logic [31:0] pc_redirect_out
);

  trap_state_t state;
  logic        take_trap, is_mret, is_irq;
  logic [31:0] cause, tval;
  logic [31:0] cause_q, tval_q, target_q;
  logic [31:0] base, target_next;
  logic        accept, hs;

  trap_cause_encoder u_enc (
    .illegal_ins_in (illegal_ins_in),
    .ecall_in       (ecall_in),
    .ebreak_in      (ebreak_in),
    .mret_in        (mret_in),
    .irq_ext_in     (irq_ext_in),
    .irq_tmr_in     (irq_tmr_in),
    .mie_in         (mstatus_in[MSTATUS_MIE]),
    .pc_in          (pc_in),
    .instr_in       (instr_in),
    .take_trap      (take_trap),
    .is_mret        (is_mret),
    .is_irq         (is_irq),
    .cause          (cause),
    .tval           (tval)
  );

  // Trap vector: vectored mode only offsets interrupts, exceptions go to base.
  always_comb begin
    base        = {mtvec_in[31:2], 2'b00};
    target_next = base;
    if (mtvec_in[1:0] == 2'b01 && is_irq)
      target_next = base + {25'd0, cause[4:0], 2'b00};
  end

  // Stall the instant an event is accepted and for the whole sequence.
  always_comb begin
    accept    = (state == ST_IDLE) && instr_valid_in && (take_trap || is_mret);
    stall_out = accept || (state != ST_IDLE);
    hs        = csr_wr_valid_out && csr_wr_ready_in;
  end

  // Sequencer: one CSR write per state, advancing only on valid&&ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= ST_IDLE;
      cause_q               <= '0;
      tval_q                <= '0;
      target_q              <= '0;
      csr_wr_valid_out      <= 1'b0;
      csr_wr_addr_out       <= '0;
      csr_wr_data_out       <= '0;
      flush_out             <= 1'b0;
      pc_redirect_valid_out <= 1'b0;
      pc_redirect_out       <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && take_trap) begin
            cause_q          <= cause;
            tval_q           <= tval;
            target_q         <= target_next;
            csr_wr_valid_out <= 1'b1;
            csr_wr_addr_out  <= CSR_MEPC;
            csr_wr_data_out  <= pc_in;
            state            <= ST_WR_EPC;
          end else if (accept) begin
            csr_wr_valid_out <= 1'b1;
            csr_wr_addr_out  <= CSR_MSTATUS;
            csr_wr_data_out  <= mstatus_on_mret(mstatus_in);
            state            <= ST_MRET_STATUS;
          end
        end
        ST_WR_EPC: if (hs) begin
          csr_wr_addr_out <= CSR_MCAUSE;
          csr_wr_data_out <= cause_q;
          state           <= ST_WR_CAUSE;
        end
        ST_WR_CAUSE: if (hs) begin
          csr_wr_addr_out <= CSR_MTVAL;
          csr_wr_data_out <= tval_q;
          state           <= ST_WR_TVAL;
        end
        ST_WR_TVAL: if (hs) begin
          csr_wr_addr_out <= CSR_MSTATUS;
          csr_wr_data_out <= mstatus_on_trap(mstatus_in);
          state           <= ST_WR_STATUS;
        end
        ST_WR_STATUS, ST_MRET_STATUS: if (hs) begin
          csr_wr_valid_out      <= 1'b0;
          csr_wr_addr_out       <= '0;
          csr_wr_data_out       <= '0;
          pc_redirect_valid_out <= 1'b1;
          flush_out             <= 1'b1;
          pc_redirect_out       <= (state == ST_MRET_STATUS) ? mepc_in : target_q;
          state                 <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          pc_redirect_valid_out <= 1'b0;
          flush_out             <= 1'b0;
          state                 <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: trap/mret sequences, backpressure, reset abort.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid_in = 1'b0;
  logic [31:0] pc_in = '0, instr_in = '0;
  logic        illegal_ins_in = 0, ecall_in = 0, ebreak_in = 0, mret_in = 0;
  logic        irq_ext_in = 0, irq_tmr_in = 0;
  logic [31:0] mstatus_in = '0, mtvec_in = '0, mepc_in = '0;
  logic        csr_wr_valid_out;
  logic [11:0] csr_wr_addr_out;
  logic [31:0] csr_wr_data_out;
  logic        csr_wr_ready_in = 1'b1;
  logic        stall_out, flush_out, pc_redirect_valid_out;
  logic [31:0] pc_redirect_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle capture after an event (index = cycle, 0 = event cycle)
  logic        r_vld [0:11];
  logic [11:0] r_addr[0:11];
  logic [31:0] r_data[0:11];
  logic        r_rv  [0:11];
  logic [31:0] r_pc  [0:11];
  logic        r_fl  [0:11];
  logic        r_st  [0:11];

  trap_controller dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .instr_valid_in        (instr_valid_in),
    .pc_in                 (pc_in),
    .instr_in              (instr_in),
    .illegal_ins_in        (illegal_ins_in),
    .ecall_in              (ecall_in),
    .ebreak_in             (ebreak_in),
    .mret_in               (mret_in),
    .irq_ext_in            (irq_ext_in),
    .irq_tmr_in            (irq_tmr_in),
    .mstatus_in            (mstatus_in),
    .mtvec_in              (mtvec_in),
    .mepc_in               (mepc_in),
    .csr_wr_valid_out      (csr_wr_valid_out),
    .csr_wr_addr_out       (csr_wr_addr_out),
    .csr_wr_data_out       (csr_wr_data_out),
    .csr_wr_ready_in       (csr_wr_ready_in),
    .stall_out             (stall_out),
    .flush_out             (flush_out),
    .pc_redirect_valid_out (pc_redirect_valid_out),
    .pc_redirect_out       (pc_redirect_out)
  );

  always #5 clk = ~clk;

  task automatic sample(input int k);
    r_vld[k] = csr_wr_valid_out; r_addr[k] = csr_wr_addr_out; r_data[k] = csr_wr_data_out;
    r_rv[k] = pc_redirect_valid_out; r_pc[k] = pc_redirect_out; r_fl[k] = flush_out;
    r_st[k] = stall_out;
  endtask

  // Present one event for one cycle and record 12 cycles; lowmask[k] drops ready in cycle k.
  task automatic run_event(input logic [31:0] pc, input logic [31:0] ins,
                           input logic il, input logic ec, input logic eb, input logic mr,
                           input logic ext, input logic tmr, input logic [11:0] lowmask);
    @(posedge clk); #1;
    instr_valid_in = 1'b1; pc_in = pc; instr_in = ins;
    illegal_ins_in = il; ecall_in = ec; ebreak_in = eb; mret_in = mr;
    irq_ext_in = ext; irq_tmr_in = tmr; csr_wr_ready_in = ~lowmask[0];
    @(negedge clk); sample(0);
    for (int k = 1; k < 12; k++) begin
      @(posedge clk); #1;
      csr_wr_ready_in = ~lowmask[k];
      if (k == 1) begin
        instr_valid_in = 0; illegal_ins_in = 0; ecall_in = 0; ebreak_in = 0;
        mret_in = 0; irq_ext_in = 0; irq_tmr_in = 0;
      end
      @(negedge clk); sample(k);
    end
    csr_wr_ready_in = 1'b1;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if (csr_wr_valid_out !== 0 || csr_wr_addr_out !== 0 || csr_wr_data_out !== 0 ||
        stall_out !== 0 || flush_out !== 0 || pc_redirect_valid_out !== 0 || pc_redirect_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: v=%b a=%h d=%h st=%b fl=%b rv=%b pc=%h, want all 0",
               csr_wr_valid_out, csr_wr_addr_out, csr_wr_data_out, stall_out, flush_out,
               pc_redirect_valid_out, pc_redirect_out);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_illegal;
    logic [11:0] ea[4] = '{12'h341, 12'h342, 12'h343, 12'h300};
    logic [31:0] ed[4] = '{32'h100, 32'd2, 32'hFFFF_FFFF, 32'h1880};
    mstatus_in = 32'h8; mtvec_in = 32'h200;
    run_event(32'h100, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 12'h0);
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (r_vld[k] !== 1 || r_addr[k] !== ea[k-1] || r_data[k] !== ed[k-1] || r_st[k] !== 1) begin
        n_fail++;
        $display("FAIL illegal_wr%0d: v=%b a=%h d=%h st=%b, want v=1 a=%h d=%h st=1",
                 k, r_vld[k], r_addr[k], r_data[k], r_st[k], ea[k-1], ed[k-1]);
      end
    end
    n_checks++;
    if (r_st[0] !== 1 || r_rv[5] !== 1 || r_fl[5] !== 1 || r_pc[5] !== 32'h200 || r_vld[5] !== 0) begin
      n_fail++;
      $display("FAIL illegal_redirect: st0=%b rv=%b fl=%b pc=%h v=%b, want 1 1 1 00000200 0",
               r_st[0], r_rv[5], r_fl[5], r_pc[5], r_vld[5]);
    end
    n_checks++;
    if (r_rv[6] !== 0 || r_fl[6] !== 0 || r_st[6] !== 0 || r_vld[6] !== 0) begin
      n_fail++;
      $display("FAIL illegal_idle6: rv=%b fl=%b st=%b v=%b, want all 0", r_rv[6], r_fl[6], r_st[6], r_vld[6]);
    end
  endtask

  task automatic test_ecall;
    mstatus_in = 32'h8; mtvec_in = 32'h200;
    run_event(32'h40, 32'h0000_0073, 0, 1, 0, 0, 0, 0, 12'h0);
    n_checks++;
    if (r_data[1] !== 32'h40 || r_data[2] !== 32'd11 || r_data[3] !== 32'd0 || r_pc[5] !== 32'h200 || r_rv[5] !== 1) begin
      n_fail++;
      $display("FAIL ecall: epc=%h cause=%h tval=%h pc=%h rv=%b, want 40 b 0 200 1",
               r_data[1], r_data[2], r_data[3], r_pc[5], r_rv[5]);
    end
  endtask

  task automatic test_ebreak;
    mstatus_in = 32'h8; mtvec_in = 32'h200;
    run_event(32'h44, 32'h0010_0073, 0, 0, 1, 0, 0, 0, 12'h0);
    n_checks++;
    if (r_data[1] !== 32'h44 || r_data[2] !== 32'd3 || r_data[3] !== 32'h44) begin
      n_fail++;
      $display("FAIL ebreak: epc=%h cause=%h tval=%h, want 44 3 44", r_data[1], r_data[2], r_data[3]);
    end
  endtask

  task automatic test_irq_vectored;
    mstatus_in = 32'h8; mtvec_in = 32'h301;
    run_event(32'h80, 32'h0000_0073, 0, 1, 0, 0, 0, 1, 12'h0);
    n_checks++;
    if (r_data[1] !== 32'h80 || r_data[2] !== 32'h8000_0007 || r_data[3] !== 32'd0 || r_data[4] !== 32'h1880) begin
      n_fail++;
      $display("FAIL irq_tmr_writes: epc=%h cause=%h tval=%h ms=%h, want 80 80000007 0 1880",
               r_data[1], r_data[2], r_data[3], r_data[4]);
    end
    n_checks++;
    if (r_rv[5] !== 1 || r_pc[5] !== 32'h31C) begin
      n_fail++;
      $display("FAIL irq_tmr_vector: rv=%b pc=%h, want 1 0000031c", r_rv[5], r_pc[5]);
    end
  endtask

  task automatic test_irq_masked;
    mstatus_in = 32'h0; mtvec_in = 32'h301;
    run_event(32'h80, 32'h0000_0073, 0, 1, 0, 0, 0, 1, 12'h0);
    n_checks++;
    if (r_data[2] !== 32'd11 || r_data[4] !== 32'h1800 || r_pc[5] !== 32'h300 || r_rv[5] !== 1) begin
      n_fail++;
      $display("FAIL irq_masked: cause=%h ms=%h pc=%h rv=%b, want b 1800 300 1",
               r_data[2], r_data[4], r_pc[5], r_rv[5]);
    end
  endtask

  task automatic test_mret;
    mstatus_in = 32'h80; mepc_in = 32'h1234; mtvec_in = 32'h200;
    run_event(32'h50, 32'h3020_0073, 0, 0, 0, 1, 0, 0, 12'h0);
    n_checks++;
    if (r_st[0] !== 1 || r_vld[1] !== 1 || r_addr[1] !== 12'h300 || r_data[1] !== 32'h1888) begin
      n_fail++;
      $display("FAIL mret_status: st0=%b v=%b a=%h d=%h, want 1 1 300 1888",
               r_st[0], r_vld[1], r_addr[1], r_data[1]);
    end
    n_checks++;
    if (r_rv[2] !== 1 || r_fl[2] !== 1 || r_pc[2] !== 32'h1234 || r_vld[2] !== 0 || r_rv[3] !== 0 || r_st[3] !== 0) begin
      n_fail++;
      $display("FAIL mret_redirect: rv2=%b fl2=%b pc=%h v2=%b rv3=%b st3=%b, want 1 1 1234 0 0 0",
               r_rv[2], r_fl[2], r_pc[2], r_vld[2], r_rv[3], r_st[3]);
    end
  endtask

  task automatic test_backpressure;
    mstatus_in = 32'h8; mtvec_in = 32'h200;
    run_event(32'h88, 32'h0010_0073, 0, 0, 1, 0, 0, 0, 12'b0000_0001_1100);
    for (int k = 2; k <= 5; k++) begin
      n_checks++;
      if (r_vld[k] !== 1 || r_addr[k] !== 12'h342 || r_data[k] !== 32'd3 || r_st[k] !== 1) begin
        n_fail++;
        $display("FAIL bp_hold%0d: v=%b a=%h d=%h st=%b, want 1 342 3 1", k, r_vld[k], r_addr[k], r_data[k], r_st[k]);
      end
    end
    n_checks++;
    if (r_addr[6] !== 12'h343 || r_addr[7] !== 12'h300 || r_rv[7] !== 0 || r_rv[8] !== 1 || r_pc[8] !== 32'h200 || r_st[9] !== 0) begin
      n_fail++;
      $display("FAIL bp_latency: a6=%h a7=%h rv7=%b rv8=%b pc8=%h st9=%b, want 343 300 0 1 200 0",
               r_addr[6], r_addr[7], r_rv[7], r_rv[8], r_pc[8], r_st[9]);
    end
  endtask

  task automatic test_reset_abort;
    mstatus_in = 32'h8; mtvec_in = 32'h200;
    @(posedge clk); #1;
    instr_valid_in = 1; pc_in = 32'h300; instr_in = 32'hFFFF_FFFF; illegal_ins_in = 1;
    @(posedge clk); #1;
    instr_valid_in = 0; illegal_ins_in = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    csr_wr_ready_in = 0;
    @(negedge clk);
    n_checks++;
    if (csr_wr_valid_out !== 1 || csr_wr_addr_out !== 12'h343) begin
      n_fail++;
      $display("FAIL abort_in_tval: v=%b a=%h, want 1 343", csr_wr_valid_out, csr_wr_addr_out);
    end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if (csr_wr_valid_out !== 0 || csr_wr_addr_out !== 0 || csr_wr_data_out !== 0 || stall_out !== 0 ||
        flush_out !== 0 || pc_redirect_valid_out !== 0 || pc_redirect_out !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_async: v=%b a=%h d=%h st=%b fl=%b rv=%b pc=%h, want all 0",
               csr_wr_valid_out, csr_wr_addr_out, csr_wr_data_out, stall_out, flush_out,
               pc_redirect_valid_out, pc_redirect_out);
    end
    @(posedge clk); #1;
    rst_n = 1; csr_wr_ready_in = 1;
    @(negedge clk);
    n_checks++;
    if (csr_wr_valid_out !== 0 || stall_out !== 0) begin
      n_fail++;
      $display("FAIL abort_idle: v=%b st=%b, want 0 0", csr_wr_valid_out, stall_out);
    end
    run_event(32'h40, 32'h0000_0073, 0, 1, 0, 0, 0, 0, 12'h0);
    n_checks++;
    if (r_addr[1] !== 12'h341 || r_data[1] !== 32'h40 || r_rv[5] !== 1) begin
      n_fail++;
      $display("FAIL abort_restart: a=%h d=%h rv5=%b, want 341 40 1", r_addr[1], r_data[1], r_rv[5]);
    end
  endtask

  initial begin
    test_reset;
    test_illegal;
    test_ecall;
    test_ebreak;
    test_irq_vectored;
    test_irq_masked;
    test_mret;
    test_backpressure;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
